tm1638_key_events: RTL and testbench
====================================

# tm1638_key_events

Key-event conditioner downstream of the TM1638 board controller. It takes the raw scanned `keys` vector, which is sampled roughly every few milliseconds and may bounce, and turns it into debounced key levels. It emits one-cycle press, release and (optionally) auto-repeat pulses, plus a priority-encoded event port, for consumption by lab logic.

## Interface
- `clk_mhz`, 50: clock frequency in MHz; sets the 1 ms tick prescaler.
- `w_key`, 8: number of keys. Use 16 for the HCW-132 board.
- `debounce_ms`, 10: number of consecutive ms ticks of a changed input required to accept it; range 1..255.
- `repeat_delay_ms`, 500: hold time before the first repeat pulse; range 1..4095.
- `repeat_rate_ms`, 100: period between subsequent repeat pulses; range 1..4095.
- `clk`  in  1: single clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `keys`  in  w_key: raw key levels from the board controller; asynchronous to decoded timing.
- `key_state`  out  w_key: debounced level, 1 = held.
- `key_press`  out  w_key: one-cycle pulse per key on accepted 0→1.
- `key_release`  out  w_key: one-cycle pulse per key on accepted 1→0.
- `key_repeat`  out  w_key: one-cycle auto-repeat pulse per held key.
- `event_valid`  out  1: any pulse this cycle.
- `event_key`  out  $clog2(w_key): index of the reported key.
- `event_type`  out  2: 0 press, 1 release, 2 repeat.

## Operation
- Input path: 2-FF synchronizer on `keys`.
- ms tick: prescaler counts 0..clk_mhz*1000-1. `tick` is high for one cycle at the terminal count, then the prescaler wraps to 0.
- Per-key FSM, with states:
  - IDLE: key_state=0.
  - PRESS_CHK: sync=1 seen.
  - HELD: key_state=1.
  - RELEASE_CHK: sync=0 seen.
- Transitions:
  - IDLE→PRESS_CHK when sync=1. The debounce counter is cleared.
  - PRESS_CHK, on `tick` with sync=1: increment the counter. When the count reaches debounce_ms, go to HELD.
  - PRESS_CHK, sync=0 on any cycle: return to IDLE. No pulse is produced.
  - HELD→RELEASE_CHK when sync=0. The counter is cleared.
  - RELEASE_CHK: mirror of PRESS_CHK. On completion go to IDLE. If sync returns to 1, go back to HELD with no pulse.
- Repeat counter (ms ticks) per key:
  - Cleared on entry to HELD.
  - Counts on `tick` while in HELD or RELEASE_CHK.
  - Pulses `key_repeat` at repeat_delay_ms, then every repeat_rate_ms.
  - Counter is 12-bit. It reloads to repeat_delay_ms−repeat_rate_ms after each pulse, so it never wraps.
- Event encoder:
  - Reports the lowest-index key with any pulse.
  - Type priority within a key: press > release > repeat.
  - Pulses lost to the encoder remain visible on the vector outputs. The encoder does not queue.
- Reset: all FSMs go to IDLE; all counters clear; synchronizer flops clear.

## Timing
- Every output is registered. All outputs are 0 in reset and in the first cycle after it.
- Latency from an edge on `keys` to `key_press`:
  - 2 synchronizer cycles, plus the time to collect debounce_ms ticks, plus 1 cycle.
  - Total is between (debounce_ms−1) ms and debounce_ms ms plus 3 cycles.
- `key_press` and `key_state` rise in the same cycle. `key_release` is asserted in the same cycle `key_state` falls.
- Pulses are exactly 1 cycle wide. Multiple keys may pulse in the same cycle.
- `event_*` outputs are valid in the same cycle as the vector pulses. `event_key`/`event_type` are 0 when `event_valid`=0.
- `rst` asserted mid-debounce or mid-repeat aborts immediately with no pulse. After deassertion, a key still held produces a fresh press after a full debounce.

## Configuration
- Macro: `TM1638_KEY_EVENTS_AUTOREPEAT_EN`.
- Defined: repeat counters and `key_repeat` are implemented as described.
- Undefined:
  - `key_repeat` is tied to 0 and the repeat counters are not built.
  - The repeat parameters are accepted but ignored.
  - `event_type`=2 never occurs.

## Structure
- Package `tm1638_key_events_pkg` holds:
  - the per-key state enum (IDLE, PRESS_CHK, HELD, RELEASE_CHK);
  - the event type constants `EV_PRESS`=0, `EV_RELEASE`=1, `EV_REPEAT`=2;
  - the counter width constants (8-bit debounce, 12-bit repeat).
- Sub-module `tm1638_key_debounce`: one key's FSM plus its debounce and repeat counters. It is instantiated w_key times in a generate loop. The top module holds the synchronizer, the tick prescaler and the encoder.

## Test plan
The bench uses clk_mhz=1 (tick every 1000 cycles), debounce_ms=3, repeat_delay_ms=10, repeat_rate_ms=4.
- **Clean press.** Hold keys[2]=1 for 10 ms → one `key_press`[2] pulse 3 ms ±1 ms after the edge; `key_state`[2]=1; event_key=2, type 0.
- **Bounce.** keys[0] toggles every 500 cycles for 5 ms, then settles at 1 → exactly one press, no release, press ≤3 ms after settling.
- **Repeat** (macro defined). Hold keys[5] for 30 ms → press, then repeats at +10, +14, +18, +22, +26 ms after the press. Release → one `key_release`. With the macro undefined → zero repeats.
- **Simultaneous.** keys[1] and keys[6] rise in the same cycle → both press bits set in one cycle; event_key=1.
- **Reset mid-op.** Assert `rst` 2 ms into the debounce of keys[3] with the key held → all outputs 0. After release of reset, the press arrives about 3 ms later.
- **Glitch reject.** A 2 ms-wide pulse on keys[4] → no pulses and `key_state`[4] stays 0.

Source files
------------

// File: rtl/tm1638_key_events_pkg.sv
// rtl/tm1638_key_events_pkg.sv - shared types and constants for the TM1638 key-event conditioner
package tm1638_key_events_pkg;

    // Per-key debounce state
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } key_fsm_e;

    // Encoded event types reported on event_type
    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_REPEAT  = 2'd2;

    // Counter widths: debounce in ms ticks (1..255), repeat in ms ticks (1..4095)
    localparam int DEB_W = 8;
    localparam int REP_W = 12;

endpackage

// File: rtl/tm1638_key_debounce.sv
// rtl/tm1638_key_debounce.sv - one key's debounce FSM, debounce counter and optional repeat counter (TM1638_KEY_EVENTS_AUTOREPEAT_EN)
module tm1638_key_debounce
    import tm1638_key_events_pkg::*;
#(
    parameter int debounce_ms     = 10,
    parameter int repeat_delay_ms = 500,
    parameter int repeat_rate_ms  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_sync,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_repeat,
    output logic press_nxt,
    output logic release_nxt,
    output logic repeat_nxt
);

    // The repeat reload value is delay-rate, so the rate may not exceed the delay.
    if (debounce_ms < 1 || debounce_ms > 255 || repeat_delay_ms < 1 || repeat_delay_ms > 4095 ||
        repeat_rate_ms < 1 || repeat_rate_ms > repeat_delay_ms) begin : g_bad_params
        $error("tm1638_key_debounce: parameter out of range");
    end

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(debounce_ms - 1);

    key_fsm_e         state;
    key_fsm_e         state_nxt;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_cnt_nxt;
    logic             deb_done;

    // The tick that completes a debounce is the debounce_ms-th one collected.
    assign deb_done = tick && (deb_cnt == DEB_LAST);

    // Next-state and pulse decode for the debounce FSM
    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (key_sync) begin
                    state_nxt   = PRESS_CHK;
                    deb_cnt_nxt = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_sync) begin
                    state_nxt = IDLE;
                end else if (deb_done) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                end else if (tick) begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!key_sync) begin
                    state_nxt   = RELEASE_CHK;
                    deb_cnt_nxt = '0;
                end
            end
            RELEASE_CHK: begin
                if (key_sync) begin
                    state_nxt = HELD;
                end else if (deb_done) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else if (tick) begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef TM1638_KEY_EVENTS_AUTOREPEAT_EN
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(repeat_delay_ms - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(repeat_delay_ms - repeat_rate_ms);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;
    logic             hold_run;

    // Repeat timing: restarts on every entry to HELD, runs while the key is still considered held
    always_comb begin
        rep_cnt_nxt = rep_cnt;
        repeat_nxt  = 1'b0;
        hold_run    = (state == HELD) || (state == RELEASE_CHK && !key_sync && !deb_done);
        if (state_nxt == HELD && state != HELD) begin
            rep_cnt_nxt = '0;
        end else if (hold_run && tick) begin
            if (rep_cnt == REP_LAST) begin
                repeat_nxt  = 1'b1;
                rep_cnt_nxt = REP_RELOAD;
            end else begin
                rep_cnt_nxt = rep_cnt + 1'b1;
            end
        end
    end

    // Repeat counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt_nxt;
        end
    end
`else
    assign repeat_nxt = 1'b0;
`endif

    // FSM, debounce counter and registered key outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            state       <= state_nxt;
            deb_cnt     <= deb_cnt_nxt;
            key_state   <= (state_nxt == HELD) || (state_nxt == RELEASE_CHK);
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_repeat  <= repeat_nxt;
        end
    end

endmodule

// File: rtl/tm1638_key_events.sv
// rtl/tm1638_key_events.sv - key synchronizer, ms tick, per-key debounce and event encoder (auto-repeat under TM1638_KEY_EVENTS_AUTOREPEAT_EN)
module tm1638_key_events
    import tm1638_key_events_pkg::*;
#(
    parameter int clk_mhz         = 50,
    parameter int w_key           = 8,
    parameter int debounce_ms     = 10,
    parameter int repeat_delay_ms = 500,
    parameter int repeat_rate_ms  = 100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [w_key-1:0]           keys,
    output logic [w_key-1:0]           key_state,
    output logic [w_key-1:0]           key_press,
    output logic [w_key-1:0]           key_release,
    output logic [w_key-1:0]           key_repeat,
    output logic                       event_valid,
    output logic [$clog2(w_key)-1:0]   event_key,
    output logic [1:0]                 event_type
);

    localparam int KW        = $clog2(w_key);
    localparam int TICK_LAST = clk_mhz * 1000 - 1;
    localparam int PW        = $clog2(clk_mhz * 1000);

    logic [w_key-1:0] sync_q1;
    logic [w_key-1:0] sync_q2;
    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [w_key-1:0] press_nxt;
    logic [w_key-1:0] release_nxt;
    logic [w_key-1:0] repeat_nxt;
    logic             ev_valid_nxt;
    logic [KW-1:0]    ev_key_nxt;
    logic [1:0]       ev_type_nxt;

    // Two-flop synchronizer on the raw key levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= keys;
            sync_q2 <= sync_q1;
        end
    end

    assign tick = (pre_cnt == PW'(TICK_LAST));

    // 1 ms prescaler, wraps to 0 after the terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < w_key; k++) begin : g_key
        tm1638_key_debounce #(
            .debounce_ms     (debounce_ms),
            .repeat_delay_ms (repeat_delay_ms),
            .repeat_rate_ms  (repeat_rate_ms)
        ) u_deb (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .key_sync    (sync_q2[k]),
            .key_state   (key_state[k]),
            .key_press   (key_press[k]),
            .key_release (key_release[k]),
            .key_repeat  (key_repeat[k]),
            .press_nxt   (press_nxt[k]),
            .release_nxt (release_nxt[k]),
            .repeat_nxt  (repeat_nxt[k])
        );
    end

    // Lowest-index key wins; downward scan lets the lowest index write last
    always_comb begin
        ev_valid_nxt = 1'b0;
        ev_key_nxt   = '0;
        ev_type_nxt  = EV_PRESS;
        for (int i = w_key - 1; i >= 0; i--) begin
            if (press_nxt[i] || release_nxt[i] || repeat_nxt[i]) begin
                ev_valid_nxt = 1'b1;
                ev_key_nxt   = KW'(i);
                ev_type_nxt  = press_nxt[i] ? EV_PRESS : (release_nxt[i] ? EV_RELEASE : EV_REPEAT);
            end
        end
    end

    // Event port registered alongside the per-key pulse vectors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_valid <= 1'b0;
            event_key   <= '0;
            event_type  <= EV_PRESS;
        end else begin
            event_valid <= ev_valid_nxt;
            event_key   <= ev_key_nxt;
            event_type  <= ev_type_nxt;
        end
    end

endmodule

// File: tb/tb_tm1638_key_events.sv
// tb/tb_tm1638_key_events.sv - self-checking bench for tm1638_key_events with a level/pending reference model
module tb_tm1638_key_events;
    import tm1638_key_events_pkg::*;

    localparam int W     = 8;
    localparam int DEB   = 3;
    localparam int RDLY  = 10;
    localparam int RRATE = 4;
    localparam int TICK  = 1000;
`ifdef TM1638_KEY_EVENTS_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] keys;
    logic [W-1:0] key_state, key_press, key_release, key_repeat;
    logic         event_valid;
    logic [2:0]   event_key;
    logic [1:0]   event_type;

    always #5 clk = ~clk;

    tm1638_key_events #(
        .clk_mhz(1), .w_key(W), .debounce_ms(DEB),
        .repeat_delay_ms(RDLY), .repeat_rate_ms(RRATE)
    ) dut (
        .clk(clk), .rst(rst), .keys(keys),
        .key_state(key_state), .key_press(key_press),
        .key_release(key_release), .key_repeat(key_repeat),
        .event_valid(event_valid), .event_key(event_key), .event_type(event_type)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: debounced level plus a "pending change" run of ticks;
    // repeats fire when ticks held since acceptance hit delay + n*rate.
    logic [W-1:0] m_s1, m_s2;
    logic [W-1:0] e_state, e_press, e_rel, e_rep;
    bit           m_pend [W];
    int           m_dc   [W];
    int           m_hc   [W];
    int           m_pcnt;
    bit           m_tk, m_was, m_done, m_abort;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pcnt = 0; m_s1 = '0; m_s2 = '0;
            e_state = '0; e_press = '0; e_rel = '0; e_rep = '0;
            for (int i = 0; i < W; i++) begin
                m_pend[i] = 1'b0; m_dc[i] = 0; m_hc[i] = 0;
            end
        end else begin
            m_tk   = (m_pcnt == TICK - 1);
            m_pcnt = m_tk ? 0 : m_pcnt + 1;
            e_press = '0; e_rel = '0; e_rep = '0;
            for (int i = 0; i < W; i++) begin
                m_was = e_state[i]; m_done = 1'b0; m_abort = 1'b0;
                if (m_s2[i] != e_state[i]) begin
                    if (!m_pend[i]) begin
                        m_pend[i] = 1'b1; m_dc[i] = 0;
                    end else if (m_tk) begin
                        m_dc[i]++;
                        if (m_dc[i] == DEB) begin
                            m_pend[i] = 1'b0;
                            if (m_was) begin
                                e_rel[i] = 1'b1; e_state[i] = 1'b0; m_done = 1'b1;
                            end else begin
                                e_press[i] = 1'b1; e_state[i] = 1'b1; m_hc[i] = 0;
                            end
                        end
                    end
                end else begin
                    if (m_pend[i] && m_was) begin
                        m_abort = 1'b1; m_hc[i] = 0;
                    end
                    m_pend[i] = 1'b0;
                end
                if (REP_ON && m_was && m_tk && !m_done && !m_abort) begin
                    m_hc[i]++;
                    if (m_hc[i] >= RDLY && ((m_hc[i] - RDLY) % RRATE) == 0) e_rep[i] = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = keys;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    logic       x_v;
    logic [2:0] x_k;
    logic [1:0] x_t;
    always @(negedge clk) begin
        if (cmp_en) begin
            x_v = 1'b0; x_k = '0; x_t = '0;
            for (int i = W - 1; i >= 0; i--) begin
                if (e_press[i] || e_rel[i] || e_rep[i]) begin
                    x_v = 1'b1; x_k = 3'(i);
                    x_t = e_press[i] ? 2'd0 : (e_rel[i] ? 2'd1 : 2'd2);
                end
            end
            chk("vectors", {key_state, key_press, key_release, key_repeat}, {e_state, e_press, e_rel, e_rep});
            chk("event", {26'd0, event_valid, event_key, event_type}, {26'd0, x_v, x_k, x_t});
        end
    end

    // Pulse counters for the directed scenarios
    int n_press [W];
    int n_rel   [W];
    int n_rep   [W];
    int rep5_q  [$];
    always @(negedge clk) begin
        for (int i = 0; i < W; i++) begin
            if (key_press[i] === 1'b1)   n_press[i]++;
            if (key_release[i] === 1'b1) n_rel[i]++;
            if (key_repeat[i] === 1'b1)  n_rep[i]++;
        end
        if (key_repeat[5] === 1'b1) rep5_q.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < W; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_rep[i] = 0;
        end
        rep5_q.delete();
    endtask

    task automatic wait_press(input int k, input int limit, output int at);
        int c;
        c  = 0;
        at = -1;
        while (c < limit && at < 0) begin
            @(negedge clk);
            if (key_press[k] === 1'b1) at = cyc;
            c++;
        end
        if (at < 0) begin
            n_checks++; n_errors++;
            $display("FAIL press_timeout key %0d: no press within %0d cycles", k, limit);
        end
    endtask

    int t0, at, p;

    initial begin
        rst  = 1'b1;
        keys = '0;
        step(2);
        cmp_en = 1'b1;
        step(3);
        chk("reset_state", key_state, 0);
        chk("reset_pulses", {key_press, key_release, key_repeat}, 0);
        chk("reset_event", {event_valid, event_key, event_type}, 0);
        rst = 1'b0;
        step(1);
        chk("first_cycle_after_reset", {key_state, key_press, event_valid}, 0);

        // Clean press on key 2
        clear_counts();
        t0 = cyc; keys[2] = 1'b1;
        wait_press(2, 5000, at);
        chk($sformatf("press2_latency_%0d_in_2000_3003", at - t0), ((at - t0) >= 2000 && (at - t0) <= 3003), 1);
        chk("press2_state", key_state[2], 1);
        chk("press2_event_key", event_key, 2);
        chk("press2_event_type", event_type, EV_PRESS);
        step(2000);
        keys[2] = 1'b0;
        step(3100);
        chk("press2_count", n_press[2], 1);
        chk("release2_count", n_rel[2], 1);

        // Bounce on key 0, then settle high
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            keys[0] = ~keys[0];
            step(500);
        end
        t0 = cyc; keys[0] = 1'b1;
        wait_press(0, 5000, at);
        chk($sformatf("bounce_latency_%0d_le_3003", at - t0), ((at - t0) <= 3003), 1);
        step(10);
        chk("bounce_press_count", n_press[0], 1);
        chk("bounce_release_count", n_rel[0], 0);
        keys[0] = 1'b0;
        step(3100);

        // Held key 5: repeats at press + 10, 14, 18, 22, 26 ms
        clear_counts();
        t0 = cyc; keys[5] = 1'b1;
        wait_press(5, 5000, p);
        step(29000 - (cyc - t0));
        keys[5] = 1'b0;
        step(3100);
        chk("repeat5_count", n_rep[5], REP_ON ? 5 : 0);
        for (int i = 0; i < rep5_q.size() && i < 5; i++)
            chk($sformatf("repeat5_offset_%0d", i), rep5_q[i] - p, 10000 + 4000 * i);
        chk("repeat5_press_count", n_press[5], 1);
        chk("repeat5_release_count", n_rel[5], 1);

        // Simultaneous keys 1 and 6
        clear_counts();
        keys[1] = 1'b1; keys[6] = 1'b1;
        wait_press(1, 5000, at);
        chk("simul_press6_same_cycle", key_press[6], 1);
        chk("simul_event_key", event_key, 1);
        chk("simul_event_type", event_type, EV_PRESS);
        step(10);
        keys[1] = 1'b0; keys[6] = 1'b0;
        step(3100);
        chk("simul_releases", {n_rel[1][7:0], n_rel[6][7:0]}, 16'h0101);

        // Reset 2 ms into the debounce of key 3
        clear_counts();
        keys[3] = 1'b1;
        step(2002);
        rst = 1'b1;
        @(negedge clk);
        chk("midop_reset_outputs", {key_state, key_press, key_release, key_repeat}, 0);
        chk("midop_reset_event", {event_valid, event_key, event_type}, 0);
        step(3);
        rst = 1'b0;
        t0 = cyc;
        wait_press(3, 5000, at);
        chk($sformatf("post_reset_latency_%0d_in_2000_3003", at - t0), ((at - t0) >= 2000 && (at - t0) <= 3003), 1);
        step(10);
        chk("post_reset_press_count", n_press[3], 1);
        keys[3] = 1'b0;
        step(3100);

        // 2 ms glitch on key 4 must be rejected
        clear_counts();
        keys[4] = 1'b1;
        step(2000);
        keys[4] = 1'b0;
        step(3100);
        chk("glitch_press_count", n_press[4], 0);
        chk("glitch_release_count", n_rel[4], 0);
        chk("glitch_state", key_state[4], 0);

        // Randomized key traffic, checked cycle by cycle against the model
        for (int s = 0; s < 12; s++) begin
            keys = W'($urandom);
            step($urandom_range(50, 1500));
        end
        keys = '0;
        step(3100);
        chk("random_all_released", key_state, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
